// File: rtl/piso_framer.sv
// piso_framer: parallel-in, serial-out framer.
// Accepts W-bit words over valid/ready into a one-word holding register.
// Each bit_en strobe emits one framed bit on sdo: a start bit (1), then
// the data MSB first, then an optional parity bit, then STOP_BITS zeros.
// The idle line level is 0. Back-to-back frames follow with no idle gap
// when the holding register is refilled during a frame.
module piso_framer #(
    parameter int W          = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         sdo,
    output logic         busy,
    output logic         frame_done
);

    // The bit counter must hold the larger of the data length and the
    // stop-bit count.
    localparam int CNT_MAX = (W > STOP_BITS) ? W : STOP_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(W);
    localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(STOP_BITS);

    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity of a whole word; odd parity is the inverted XOR reduction.
    function automatic logic calc_parity(input logic [W-1:0] word, input logic odd);
        calc_parity = (^word) ^ odd;
    endfunction

    state_t         state_r, state_s;
    logic [W-1:0]   hold_r, hold_s;
    logic           hold_full_r, hold_full_s;
    logic [W-1:0]   shift_r, shift_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic           par_r, par_s;
    logic           sdo_r, sdo_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic           load_s;
    logic           accept_s;

    // in_ready depends only on the hold_full flop, never on in_valid.
    assign in_ready   = ~hold_full_r;
    assign sdo        = sdo_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

    // Next-state, datapath and registered-output decode for the framer.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        par_s       = par_r;
        sdo_s       = sdo_r;
        done_s      = 1'b0;
        load_s      = 1'b0;
        accept_s    = in_valid & ~hold_full_r;

        // Handshake runs on every clk edge, regardless of bit_en.
        if (accept_s) begin
            hold_s      = in_data;
            hold_full_s = 1'b1;
        end else begin
            hold_s      = hold_r;
            hold_full_s = hold_full_r;
        end

        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    sdo_s = 1'b0;
                    if (hold_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    state_s = DATA;
                    sdo_s   = shift_r[W-1];
                    shift_s = {shift_r[W-2:0], 1'b0};
                    cnt_s   = CNT_ONE;
                end
                DATA: begin
                    if (cnt_r == W_CNT) begin
                        if (PAR_EN) begin
                            state_s = PARITY;
                            sdo_s   = par_r;
                        end else begin
                            state_s = STOP;
                            sdo_s   = 1'b0;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        sdo_s   = shift_r[W-1];
                        shift_s = {shift_r[W-2:0], 1'b0};
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    state_s = STOP;
                    sdo_s   = 1'b0;
                    cnt_s   = CNT_ONE;
                end
                STOP: begin
                    if (cnt_r == STOP_CNT) begin
                        done_s = 1'b1;
                        if (hold_full_r) begin
                            load_s = 1'b1;
                        end else begin
                            state_s = IDLE;
                            sdo_s   = 1'b0;
                            cnt_s   = CNT_ZERO;
                        end
                    end else begin
                        sdo_s = 1'b0;
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    sdo_s   = 1'b0;
                    cnt_s   = CNT_ZERO;
                end
            endcase

            // Moving the held word into the shift register starts a new
            // frame; parity is computed from the latched word here.
            if (load_s) begin
                state_s     = START;
                shift_s     = hold_r;
                par_s       = calc_parity(hold_r, PAR_ODD);
                hold_full_s = 1'b0;
                sdo_s       = 1'b1;
                cnt_s       = CNT_ZERO;
            end else begin
                par_s = par_r;
            end
        end else begin
            state_s = state_r;
            sdo_s   = sdo_r;
        end

        busy_s = (state_s != IDLE) | hold_full_s;
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            shift_r     <= '0;
            cnt_r       <= CNT_ZERO;
            par_r       <= 1'b0;
            sdo_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            shift_r     <= shift_s;
            cnt_r       <= cnt_s;
            par_r       <= par_s;
            sdo_r       <= sdo_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

endmodule

// File: tb/tb_piso_framer.sv
// Directed bench for piso_framer. Three instances share the stimulus:
//   0: even parity, 1 stop bit
//   1: no parity,   1 stop bit
//   2: odd parity,  2 stop bits
// Each test resets all instances and checks only the one it targets.
module tb_piso_framer;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] rdy_v;
    logic [2:0] sdo_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int          checks;
    int          failures;
    logic [31:0] seq;
    int          dcnt;
    int          acc;
    int          acc_at;

    piso_framer #(.W(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_v[0]), .sdo(sdo_v[0]),
        .busy(busy_v[0]), .frame_done(done_v[0]));

    piso_framer #(.W(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_v[1]), .sdo(sdo_v[1]),
        .busy(busy_v[1]), .frame_done(done_v[1]));

    piso_framer #(.W(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_v[2]), .sdo(sdo_v[2]),
        .busy(busy_v[2]), .frame_done(done_v[2]));

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int idx);
        seq  = {seq[30:0], sdo_v[idx]};
        dcnt = dcnt + int'(done_v[idx]);
    endtask

    task automatic collect(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            sample(idx);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        bit_en   = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        seq      = 32'h0;
        dcnt     = 0;
    endtask

    // Directed test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        seq      = 32'h0;
        dcnt     = 0;
        reset    = 1'b1;
        bit_en   = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;

        // Reset state of all three instances.
        tick();
        check("rst_sdo",   32'(sdo_v),  32'(3'b000));
        check("rst_busy",  32'(busy_v), 32'(3'b000));
        check("rst_done",  32'(done_v), 32'(3'b000));
        check("rst_ready", 32'(rdy_v),  32'(3'b111));

        // Test 1: single frame 4'b1011, even parity.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'b1011;
        tick();
        in_valid = 1'b0;
        check("t1_ready_after_accept", 32'(rdy_v[0]), 32'(1'b0));
        check("t1_busy_after_accept",  32'(busy_v[0]), 32'(1'b1));
        tick();
        sample(0);
        check("t1_start_bit",  32'(sdo_v[0]), 32'(1'b1));
        check("t1_ready_back", 32'(rdy_v[0]), 32'(1'b1));
        collect(0, 9);
        check("t1_sdo_seq",   seq, 32'(10'b1101110000));
        check("t1_done_cnt",  32'(dcnt), 32'(1));
        check("t1_busy_end",  32'(busy_v[0]), 32'(1'b0));

        // Test 2: back-to-back 4'hA then 4'h5, no parity.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();
        in_data  = 4'h5;
        tick();
        sample(1);
        check("t2_ready_after_load", 32'(rdy_v[1]), 32'(1'b1));
        tick();
        sample(1);
        in_valid = 1'b0;
        check("t2_second_accept", 32'(rdy_v[1]), 32'(1'b0));
        collect(1, 13);
        check("t2_sdo_seq",  seq, 32'(15'b110100101010000));
        check("t2_done_cnt", 32'(dcnt), 32'(2));
        check("t2_busy_end", 32'(busy_v[1]), 32'(1'b0));

        // Test 3: backpressure while a frame is in flight and a word is held.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'h3;
        tick();
        in_data  = 4'h9;
        tick();
        tick();
        acc    = 0;
        acc_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (rdy_v[1]) begin
                in_data = 4'hF;
                acc     = acc + 1;
                acc_at  = i;
            end else begin
                in_data = 4'(i);
            end
            tick();
            sample(1);
        end
        in_valid = 1'b0;
        collect(1, 8);
        check("t3_accept_cnt", 32'(acc), 32'(1));
        check("t3_accept_at",  32'(acc_at), 32'(5));
        check("t3_sdo_seq",    seq, 32'(18'b011011001011111000));
        check("t3_done_cnt",   32'(dcnt), 32'(3));

        // Test 4: bit_en high one cycle in three, word 4'h6.
        do_reset();
        bit_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h6;
        tick();
        in_valid = 1'b0;
        check("t4_accept_no_strobe", 32'(rdy_v[1]), 32'(1'b0));
        for (int c = 1; c <= 24; c++) begin
            bit_en = ((c % 3) == 0);
            tick();
            sample(1);
        end
        bit_en = 1'b1;
        check("t4_sdo_seq",  seq, 32'(24'b001110001111110000000000));
        check("t4_done_cnt", 32'(dcnt), 32'(1));

        // Test 5: odd parity, two stop bits, word 4'h0.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'h0;
        tick();
        in_valid = 1'b0;
        collect(2, 8);
        check("t5_sdo_seq",        seq, 32'(8'b10000100));
        check("t5_no_early_done",  32'(dcnt), 32'(0));
        tick();
        check("t5_done_after_stop2", 32'(done_v[2]), 32'(1'b1));
        check("t5_idle_sdo",         32'(sdo_v[2]), 32'(1'b0));

        // Test 6: reset during the second data bit of 4'hF with 4'hA held.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
        in_data  = 4'hA;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_pre_reset_sdo",  32'(sdo_v[1]), 32'(1'b1));
        check("t6_pre_reset_held", 32'(rdy_v[1]), 32'(1'b0));
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_sdo",   32'(sdo_v[1]),  32'(1'b0));
        check("t6_async_busy",  32'(busy_v[1]), 32'(1'b0));
        check("t6_async_ready", 32'(rdy_v[1]),  32'(1'b1));
        tick();
        reset = 1'b0;
        seq   = 32'h0;
        dcnt  = 0;
        collect(1, 8);
        check("t6_sdo_after_release", seq, 32'(8'b00000000));
        check("t6_no_done",           32'(dcnt), 32'(0));
        check("t6_busy_after_release", 32'(busy_v[1]), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
